// File: rtl/tdm_one_four_demux_if.sv
// Bundle between a TDM serialiser and the 1:4 demux: serial beat in, recovered frame out.
// master: the upstream/observer side (drives beats, watches the frame outputs).
// slave:  the demux itself. err_cnt exists only when DEMUX_ERRCNT_EN is defined.
interface tdm_one_four_demux_if #(
  parameter int W = 1
);
  logic         in_valid;
  logic         sof;
  logic [W-1:0] din;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [W-1:0] y4;
  logic         frame_valid;
  logic [1:0]   sel;
  logic         sync_err;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  modport master (
    output in_valid, sof, din,
    input  y1, y2, y3, y4, frame_valid, sel, sync_err
`ifdef DEMUX_ERRCNT_EN
    , err_cnt
`endif
  );

  modport slave (
    input  in_valid, sof, din,
    output y1, y2, y3, y4, frame_valid, sel, sync_err
`ifdef DEMUX_ERRCNT_EN
    , err_cnt
`endif
  );
endinterface

// File: rtl/tdm_one_four_demux.sv
// Purpose: rebuild four parallel channels from a 4-slot TDM stream, aligned on sof.
// Latency: y1..y4/frame_valid visible one edge after the slot-3 beat is sampled.
// Backpressure: none; in_valid=0 freezes all state, gaps of any length allowed.
//
// Ports: clk, rst_n (async active-low); bus (tdm_one_four_demux_if.slave):
//   in  in_valid, sof, din[W-1:0]
//   out y1..y4[W-1:0], frame_valid, sel[1:0], sync_err, err_cnt[7:0]
// Optional: DEMUX_ERRCNT_EN adds the saturating err_cnt sync-error counter.
module tdm_one_four_demux #(
  parameter int W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tdm_one_four_demux_if.slave    bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] s0_q, s0_d;
  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] y1_q, y1_d;
  logic [W-1:0] y2_q, y2_d;
  logic [W-1:0] y3_q, y3_d;
  logic [W-1:0] y4_q, y4_d;
  logic         frame_valid_q, frame_valid_d;
  logic         sync_err_q, sync_err_d;

  logic         beat;
  logic         beat_sof;
  logic [W-1:0] din;

  assign beat     = bus.in_valid;
  assign beat_sof = bus.sof;
  assign din      = bus.din;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sel_q         <= 2'd0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      y4_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      y3_q          <= y3_d;
      y4_q          <= y4_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Next-state and datapath. Everything holds by default; the two strobes
  // default low so they only ever last one cycle.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    y3_d          = y3_q;
    y4_d          = y4_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (beat) begin
      unique case (state_q)
        HUNT: begin
          // Non-sof beats carry no alignment information and are dropped
          // silently; only an sof beat can start a frame.
          if (beat_sof) begin
            s0_d    = din;
            sel_d   = 2'd1;
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          if (beat_sof) begin
            // sof mid-frame: the partial frame is abandoned (y untouched)
            // and this beat restarts alignment as slot 0.
            if (sel_q != 2'd0) begin
              sync_err_d = 1'b1;
            end
            s0_d  = din;
            sel_d = 2'd1;
          end else begin
            unique case (sel_q)
              2'd0: begin
                // Expected a frame start but got a mid-frame beat: we have
                // lost alignment, so fall back to hunting for sof.
                sync_err_d = 1'b1;
                sel_d      = 2'd0;
                state_d    = HUNT;
              end
              2'd1: begin
                s1_d  = din;
                sel_d = 2'd2;
              end
              2'd2: begin
                s2_d  = din;
                sel_d = 2'd3;
              end
              2'd3: begin
                // Slot 3 goes straight to y4; the whole frame publishes at
                // once so a partial frame can never appear on the outputs.
                y1_d          = s0_q;
                y2_d          = s1_q;
                y3_d          = s2_q;
                y4_d          = din;
                frame_valid_d = 1'b1;
                sel_d         = 2'd0;
              end
              default: begin
                sel_d = 2'd0;
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          sel_d   = 2'd0;
        end
      endcase
    end
  end

`ifdef DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside the sync_err register so the count and the pulse
  // become visible on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (sync_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.y1          = y1_q;
  assign bus.y2          = y2_q;
  assign bus.y3          = y3_q;
  assign bus.y4          = y4_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sel         = sel_q;
  assign bus.sync_err    = sync_err_q;

  // A beat either completes a frame or breaks alignment, never both.
  a_no_err_with_frame : assert property (
    @(posedge clk) disable iff (!rst_n) !(sync_err_q && frame_valid_q)
  );

  // While hunting the slot counter always sits at 0.
  a_hunt_sel_zero : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == HUNT) |-> (sel_q == 2'd0)
  );

endmodule

// File: doc/tdm_one_four_demux.md
# tdm_one_four_demux

Receive-side counterpart of the 4:1 mux. It accepts a time-division-multiplexed stream of 4-slot frames, one slot per accepted beat in select order {s1,s0} = 0,1,2,3. It rebuilds the four parallel channels and presents each complete frame as one registered parallel word set with a one-cycle `frame_valid` strobe. It sits downstream of any serialiser that cycles the mux select, and recovers slot alignment from a start-of-frame marker.

## Interface
- `W`, default 1, data width of each channel and of `din`.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  `din`/`sof` carry a beat this cycle.
- `sof`  input  1  beat is slot 0 (start of frame); only meaningful with `in_valid`.
- `din`  input  W  slot data.
- `y1`,`y2`,`y3`,`y4`  output  W each  recovered channels for slots 0,1,2,3 (x1..x4 of the mux).
- `frame_valid`  output  1  one-cycle pulse: `y1..y4` updated with a new complete frame.
- `sel`  output  2  slot index expected for the next accepted beat (mirrors mux {s1,s0}).
- `sync_err`  output  1  one-cycle pulse on an alignment violation.
- `err_cnt`  output  8  saturating sync-error count (present only with `DEMUX_ERRCNT_EN`).

## Operation
- FSM states are HUNT and LOCKED. A 2-bit slot counter drives `sel`. Shadow registers s0..s2 (W bits each) hold slots 0..2.
- In HUNT:
  - Beats without `sof` are discarded.
  - `in_valid&&sof` stores `din` to s0, sets `sel`=1 and enters LOCKED.
- In LOCKED, for each beat with `in_valid`=1:
  - sel=0, `sof`=1: store to s0, sel←1.
  - sel=0, `sof`=0: pulse `sync_err`, discard the beat, go to HUNT, sel←0.
  - sel=1 or 2, `sof`=0: store to s1/s2, sel increments.
  - sel=3, `sof`=0: y1←s0, y2←s1, y3←s2, y4←`din`; pulse `frame_valid`; sel←0; stay LOCKED.
  - sel=1..3, `sof`=1: pulse `sync_err`, drop the partial frame (y unchanged), treat this beat as slot 0 (s0←din, sel←1), stay LOCKED.
- `in_valid`=0: no state, counter, shadow or output change. Gaps of any length are allowed mid-frame.
- `y1..y4` hold their value until the next complete frame. Partial frames never reach the outputs.
- `sof` while `in_valid`=0 is ignored.

## Timing
- All outputs are registered, and all updates happen on the rising edge of `clk`.
- Reset values:
  - `y1..y4` = 0, `frame_valid` = 0, `sync_err` = 0, `sel` = 0, `err_cnt` = 0.
  - FSM = HUNT, shadows = 0.
- Reset is asynchronous assert and takes effect immediately. It releases synchronously on the next `clk` edge with `rst_n`=1.
- Reset asserted mid-frame discards the partial frame. The first frame after reset requires `sof`.
- Latency: the slot-3 beat is sampled at edge N, and `y1..y4` and `frame_valid`=1 are visible after edge N. `frame_valid` clears after edge N+1 unless another frame completes.
- Minimum frame period is 4 cycles. Back-to-back frames give `frame_valid` every 4th cycle.
- `sync_err` and `frame_valid` are never asserted in the same cycle.
- `sel` reflects the next expected slot one cycle after each accepted beat.

## Configuration
- `DEMUX_ERRCNT_EN` defined:
  - Port `err_cnt[7:0]` exists.
  - It increments on every `sync_err` pulse and saturates at 255. It clears only on reset.
- Not defined: `err_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
- W=4, reset, then 4 consecutive beats 0xA(sof),0xB,0xC,0xD: `y1..y4`=A,B,C,D with `frame_valid`=1 for exactly one cycle after the 4th beat; `sync_err` stays 0 throughout.
- Same frame with `in_valid` low for 3 cycles between beats 2 and 3: identical outputs, with `frame_valid` delayed by 3 cycles and `sel` holding at 2 during the gap.
- Beats 1,2 (first with sof), then 7(sof),8,9,6: `sync_err` pulses on the 7 beat; outputs become 7,8,9,6; the earlier 1,2 never appear on `y`.
- LOCKED after a frame, then a beat 5 with `sof`=0 at sel=0: `sync_err`=1, state HUNT; following non-sof beats are ignored until `sof`; `y` keeps the last frame.
- `rst_n` pulled low asynchronously after 2 beats: all outputs 0 immediately. A later full frame 1,2,3,4 (with sof) yields `y`=1,2,3,4.
- With `DEMUX_ERRCNT_EN`: force 260 sync errors, then `err_cnt`=255. Without the macro, the build has no `err_cnt` port.
